// File: rtl/vreg_load_sequencer.sv
// ---------------------------------------------------------------------------
// vreg_load_sequencer
//
// Gathers WORDS consecutive WORD_SIZE-bit DMA stream beats into one vector
// line and writes that line into the vector register file. A command gives
// the first destination register and the number of vectors to load. Lines
// go to consecutive registers, and addresses wrap modulo NO_OF_ELEM. The
// register file has one write port, shared with the vector ALU writeback.
// The ALU always wins that port, and the sequencer waits in WRITE until the
// port is free.
//
// Ports
//   clk        rising-edge clock
//   RESET      asynchronous, active-low reset
//   cmd_valid  load command valid
//   cmd_ready  command accepted on cmd_valid && cmd_ready (IDLE only)
//   cmd_base   first destination register
//   cmd_count  number of vectors to load (0 completes immediately)
//   s_data     DMA stream beat
//   s_valid    beat valid
//   s_ready    beat accepted on s_valid && s_ready (FILL only)
//   alu_we     ALU writeback request (highest priority)
//   alu_addr   ALU destination register
//   alu_data   ALU writeback line
//   rf_we      register file write enable
//   rf_addr    register file write address
//   rf_data    register file write data
//   busy       high whenever the sequencer is not IDLE
//   done       one-cycle pulse when a command completes
// ---------------------------------------------------------------------------
module vreg_load_sequencer #(
  parameter int WORD_SIZE  = 32,
  parameter int WORDS      = 16,
  parameter int NO_OF_ELEM = 16,
  localparam int AW = $clog2(NO_OF_ELEM),
  localparam int LW = WORDS * WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 RESET,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [AW-1:0]        cmd_base,
  input  logic [AW:0]          cmd_count,
  input  logic [WORD_SIZE-1:0] s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic                 alu_we,
  input  logic [AW-1:0]        alu_addr,
  input  logic [LW-1:0]        alu_data,
  output logic                 rf_we,
  output logic [AW-1:0]        rf_addr,
  output logic [LW-1:0]        rf_data,
  output logic                 busy,
  output logic                 done
);

  localparam int WIDX = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_reg, state_next;
  logic [AW-1:0]     cur_addr_reg, cur_addr_next;
  logic [AW:0]       remaining_reg, remaining_next;
  logic [WIDX-1:0]   word_idx_reg, word_idx_next;
  logic [WORD_SIZE-1:0] line_reg [WORDS];
  logic [LW-1:0]     line_flat;
  logic              beat_we;

  // Flatten the lane array into the write line; lane 0 is the LSB lane.
  generate
    for (genvar gi = 0; gi < WORDS; gi++) begin : g_lane
      assign line_flat[gi*WORD_SIZE +: WORD_SIZE] = line_reg[gi];
    end
  endgenerate

  // Control state registers.
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state_reg     <= IDLE;
      cur_addr_reg  <= '0;
      remaining_reg <= '0;
      word_idx_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      cur_addr_reg  <= cur_addr_next;
      remaining_reg <= remaining_next;
      word_idx_reg  <= word_idx_next;
    end
  end

  // Line buffer. Clearing it on reset means a line interrupted by reset
  // leaves nothing behind.
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < WORDS; i++) begin
        line_reg[i] <= '0;
      end
    end else if (beat_we) begin
      line_reg[word_idx_reg] <= s_data;
    end
  end

  // Next-state and handshake logic.
  always_comb begin
    state_next     = state_reg;
    cur_addr_next  = cur_addr_reg;
    remaining_next = remaining_reg;
    word_idx_next  = word_idx_reg;
    cmd_ready      = 1'b0;
    s_ready        = 1'b0;
    beat_we        = 1'b0;
    done           = 1'b0;
    busy           = (state_reg != IDLE);

    case (state_reg)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          cur_addr_next  = cmd_base;
          remaining_next = cmd_count;
          word_idx_next  = '0;
          state_next     = (cmd_count == '0) ? DONE : FILL;
        end
      end

      FILL: begin
        s_ready = 1'b1;
        if (s_valid) begin
          beat_we = 1'b1;
          if (word_idx_reg == WIDX'(WORDS - 1)) begin
            word_idx_next = '0;
            state_next    = WRITE;
          end else begin
            word_idx_next = word_idx_reg + WIDX'(1);
          end
        end
      end

      WRITE: begin
        // The write is issued only in a cycle where the ALU leaves the port free.
        if (!alu_we) begin
          remaining_next = remaining_reg - (AW+1)'(1);
          cur_addr_next  = (cur_addr_reg == AW'(NO_OF_ELEM - 1)) ? '0
                                                                 : cur_addr_reg + AW'(1);
          state_next     = (remaining_reg == (AW+1)'(1)) ? DONE : FILL;
        end
      end

      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  // Write-port arbitration: the ALU first, then the sequencer while in WRITE.
  always_comb begin
    rf_we   = 1'b0;
    rf_addr = '0;
    rf_data = '0;
    if (alu_we) begin
      rf_we   = 1'b1;
      rf_addr = alu_addr;
      rf_data = alu_data;
    end else if (state_reg == WRITE) begin
      rf_we   = 1'b1;
      rf_addr = cur_addr_reg;
      rf_data = line_flat;
    end
  end

endmodule

// File: tb/tb_vreg_load_sequencer.sv
module tb_vreg_load_sequencer;

  localparam int LW = 512;

  logic          clk;
  logic          RESET;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [3:0]    cmd_base;
  logic [4:0]    cmd_count;
  logic [31:0]   s_data;
  logic          s_valid;
  logic          s_ready;
  logic          alu_we;
  logic [3:0]    alu_addr;
  logic [LW-1:0] alu_data;
  logic          rf_we;
  logic [3:0]    rf_addr;
  logic [LW-1:0] rf_data;
  logic          busy;
  logic          done;

  vreg_load_sequencer dut (
    .clk       (clk),
    .RESET     (RESET),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_base  (cmd_base),
    .cmd_count (cmd_count),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .alu_we    (alu_we),
    .alu_addr  (alu_addr),
    .alu_data  (alu_data),
    .rf_we     (rf_we),
    .rf_addr   (rf_addr),
    .rf_data   (rf_data),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]    addr;
    logic [LW-1:0] data;
  } wr_t;

  wr_t           exp_q[$];
  int            exp_done = 0;
  int            checks = 0;
  int            errors = 0;
  logic [LW-1:0] rf_model [16];

  // Line whose lane k holds base+k.
  function automatic logic [LW-1:0] mkline(input int base);
    logic [LW-1:0] l;
    l = '0;
    for (int k = 0; k < 16; k++) l[k*32 +: 32] = 32'(base + k);
    return l;
  endfunction

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input logic [3:0] a, input logic [LW-1:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic send_cmd(input logic [3:0] base, input logic [4:0] count);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_base  = base;
    cmd_count = count;
    while (!cmd_ready && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL cmd_timeout got=cmd_ready_low expected=handshake");
    end
    tick();
    cmd_valid = 1'b0;
    $display("cmd  base=%0d count=%0d accepted", base, count);
  endtask

  task automatic send_beat(input logic [31:0] v);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data  = v;
    while (!s_ready && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout got=s_ready_low expected=handshake");
    end
    tick();
    s_valid = 1'b0;
  endtask

  // Sends 16 beats base..base+15; optionally queues the expected line write.
  task automatic send_line(input logic [3:0] addr, input int base, input bit gaps, input bit push);
    for (int k = 0; k < 16; k++) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      send_beat(32'(base + k));
    end
    if (push) push_wr(addr, mkline(base));
    $display("line addr=%0d base=%0h sent", addr, base);
  endtask

  // Monitor: every register-file write and done pulse is matched against
  // the expectations queued by the stimulus.
  always @(negedge clk) begin
    if (RESET === 1'b1) begin
      if (rf_we === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write got=addr%0d expected=no_write", rf_addr);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          if (rf_addr !== e.addr || rf_data !== e.data) begin
            errors++;
            $display("FAIL rf_write got=addr%0d data=%0h expected=addr%0d data=%0h",
                     rf_addr, rf_data, e.addr, e.data);
          end else begin
            $display("wr   addr=%0d data=%0h", rf_addr, rf_data);
          end
        end
        rf_model[rf_addr] = rf_data;
      end
      if (done === 1'b1) begin
        checks++;
        if (exp_done == 0) begin
          errors++;
          $display("FAIL unexpected_done got=1 expected=0");
        end else begin
          exp_done--;
          $display("done pulse");
        end
      end
    end
  end

  initial begin
    int n;
    RESET     = 1'b0;
    cmd_valid = 1'b0;
    cmd_base  = '0;
    cmd_count = '0;
    s_data    = '0;
    s_valid   = 1'b0;
    alu_we    = 1'b0;
    alu_addr  = '0;
    alu_data  = '0;
    for (int i = 0; i < 16; i++) rf_model[i] = '0;
    tick();
    tick();

    // Reset state, and the ALU path while reset is held.
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rf_we", rf_we, 0);
    alu_we   = 1'b1;
    alu_addr = 4'd4;
    alu_data = 512'h1234;
    #1;
    chk("rst_alu_we", rf_we, 1);
    chk("rst_alu_addr", rf_addr, 4);
    chk("rst_alu_data", rf_data, 512'h1234);
    alu_we = 1'b0;
    tick();
    RESET = 1'b1;
    tick();

    // 1: base=3 count=1, beats 0..15 without gaps.
    exp_done++;
    send_cmd(4'd3, 5'd1);
    send_line(4'd3, 0, 1'b0, 1'b1);
    chk("t1_write_we", rf_we, 1);
    chk("t1_write_addr", rf_addr, 3);
    tick();
    chk("t1_done", done, 1);
    tick();
    chk("t1_done_clear", done, 0);
    chk("t1_busy_clear", busy, 0);

    // 2: base=14 count=3 with stream gaps; addresses 14, 15, 0.
    exp_done++;
    send_cmd(4'd14, 5'd3);
    send_line(4'd14, 32'h200, 1'b1, 1'b1);
    send_line(4'd15, 32'h210, 1'b1, 1'b1);
    send_line(4'd0, 32'h220, 1'b1, 1'b1);
    tick();
    tick();
    chk("t2_busy_clear", busy, 0);

    // 3: ALU holds the port for 3 cycles while the sequencer waits in WRITE.
    exp_done++;
    send_cmd(4'd5, 5'd1);
    send_line(4'd5, 32'h300, 1'b0, 1'b0);
    alu_we   = 1'b1;
    alu_addr = 4'd5;
    alu_data = '1;
    repeat (3) push_wr(4'd5, '1);
    push_wr(4'd5, mkline(32'h300));
    repeat (3) begin
      chk("t3_stall_busy", busy, 1);
      tick();
    end
    alu_we = 1'b0;
    tick();
    tick();
    tick();
    chk("t3_reg5_final", rf_model[5], mkline(32'h300));

    // 4: count=0 -- straight from the handshake cycle to DONE, no stream.
    exp_done++;
    send_cmd(4'd6, 5'd0);
    chk("t4_done", done, 1);
    chk("t4_s_ready", s_ready, 0);
    tick();
    chk("t4_done_clear", done, 0);
    chk("t4_busy_clear", busy, 0);

    // 5: reset after 7 beats, then a clean count=1 command.
    send_cmd(4'd1, 5'd1);
    for (int k = 0; k < 7; k++) send_beat(32'hDEAD0000 + 32'(k));
    RESET = 1'b0;
    #1;
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_cmd_ready", cmd_ready, 1);
    chk("t5_rst_s_ready", s_ready, 0);
    chk("t5_rst_done", done, 0);
    chk("t5_rst_rf_we", rf_we, 0);
    tick();
    RESET = 1'b1;
    tick();
    exp_done++;
    send_cmd(4'd1, 5'd1);
    send_line(4'd1, 32'h500, 1'b0, 1'b1);
    tick();
    tick();

    // 6: a command held while busy waits until IDLE after done.
    exp_done += 2;
    send_cmd(4'd2, 5'd1);
    cmd_valid = 1'b1;
    cmd_base  = 4'd7;
    cmd_count = 5'd0;
    chk("t6_fill_cmd_ready", cmd_ready, 0);
    send_line(4'd2, 32'h600, 1'b0, 1'b1);
    chk("t6_write_cmd_ready", cmd_ready, 0);
    tick();
    chk("t6_done_cmd_ready", cmd_ready, 0);
    chk("t6_first_done", done, 1);
    tick();
    chk("t6_idle_cmd_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    chk("t6_second_done", done, 1);
    tick();
    chk("t6_busy_clear", busy, 0);

    // Drain: every queued write and done must have been seen.
    n = 0;
    while ((exp_q.size() != 0 || exp_done != 0) && n < 100) begin
      tick();
      n++;
    end
    chk("end_writes_pending", exp_q.size(), 0);
    chk("end_done_pending", exp_done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
